// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, sharing one req/ready memory port between IR and data.
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel_data,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       ResultSrc,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             Jalr,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_SLTU  = 3'b110;
    localparam logic [2:0] ALU_SHIFT = 3'b111;

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    state_t            cur_state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expired;

    logic is_r;
    logic is_i;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_u;
    logic legal;
    logic [2:0] alu_arith;
    logic [2:0] alu_branch;
    logic branch_taken;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_u      = (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign legal     = is_r || is_i || is_load || is_store || is_branch ||
                       is_jal || is_jalr || is_u;

    // Immediate arithmetic has no subtract, so funct7b5 only selects sub for R-type.
    always_comb begin
        alu_arith = ALU_ADD;
        case (funct3)
            3'b000:  alu_arith = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_arith = ALU_AND;
            3'b110:  alu_arith = ALU_OR;
            3'b100:  alu_arith = ALU_XOR;
            3'b010:  alu_arith = ALU_SLT;
            3'b011:  alu_arith = ALU_SLTU;
            3'b001:  alu_arith = ALU_SHIFT;
            3'b101:  alu_arith = ALU_SHIFT;
            default: alu_arith = ALU_ADD;
        endcase
    end

    // For slt/sltu compares a non-zero result means "less than".
    always_comb begin
        alu_branch   = ALU_SUB;
        branch_taken = 1'b0;
        case (funct3)
            3'b000: begin alu_branch = ALU_SUB;  branch_taken = Zero;  end
            3'b001: begin alu_branch = ALU_SUB;  branch_taken = !Zero; end
            3'b100: begin alu_branch = ALU_SLT;  branch_taken = !Zero; end
            3'b101: begin alu_branch = ALU_SLT;  branch_taken = Zero;  end
            3'b110: begin alu_branch = ALU_SLTU; branch_taken = !Zero; end
            3'b111: begin alu_branch = ALU_SLTU; branch_taken = Zero;  end
            default: begin alu_branch = ALU_SUB; branch_taken = 1'b0;  end
        endcase
    end

    assign wait_expired = (TIMEOUT > 0) && mem_req && !mem_ready &&
                          (int'(wait_cnt) == TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= BOOT;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            BOOT:    next_state = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    next_state = DECODE;
                end else if (wait_expired) begin
                    next_state = TRAP;
                end
            end
            DECODE:  next_state = legal ? EXEC : TRAP;
            EXEC:    next_state = (is_load || is_store) ? MEM : FETCH;
            MEM: begin
                if (mem_ready) begin
                    next_state = is_store ? FETCH : WB;
                end else if (wait_expired) begin
                    next_state = TRAP;
                end
            end
            WB:      next_state = FETCH;
            TRAP:    next_state = TRAP;
            default: next_state = BOOT;
        endcase
    end

    // MEM keeps the EXEC address operands so ALUResult stays stable across wait states.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        ResultSrc    = 2'b00;
        PCSrc        = 1'b0;
        ALUSrc       = 1'b0;
        RegWrite     = 1'b0;
        ImmSrc       = 2'b00;
        ALUControl   = ALU_ADD;
        Jalr         = 1'b0;
        case (cur_state)
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            EXEC: begin
                if (is_r) begin
                    RegWrite   = 1'b1;
                    pc_we      = 1'b1;
                    ALUControl = alu_arith;
                end else if (is_i) begin
                    ALUSrc     = 1'b1;
                    RegWrite   = 1'b1;
                    pc_we      = 1'b1;
                    ALUControl = alu_arith;
                end else if (is_u) begin
                    ResultSrc = 2'b11;
                    RegWrite  = 1'b1;
                    pc_we     = 1'b1;
                end else if (is_branch) begin
                    ImmSrc     = 2'b10;
                    pc_we      = 1'b1;
                    ALUControl = alu_branch;
                    PCSrc      = branch_taken;
                end else if (is_jal) begin
                    ImmSrc    = 2'b11;
                    PCSrc     = 1'b1;
                    ResultSrc = 2'b10;
                    RegWrite  = 1'b1;
                    pc_we     = 1'b1;
                end else if (is_jalr) begin
                    ALUSrc    = 1'b1;
                    Jalr      = 1'b1;
                    ResultSrc = 2'b10;
                    RegWrite  = 1'b1;
                    pc_we     = 1'b1;
                end else if (is_load || is_store) begin
                    ALUSrc = 1'b1;
                    ImmSrc = is_store ? 2'b01 : 2'b00;
                end
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                mem_we       = is_store;
                ALUSrc       = 1'b1;
                ImmSrc       = is_store ? 2'b01 : 2'b00;
                pc_we        = is_store && mem_ready;
            end
            WB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                pc_we     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (mem_req && !mem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal <= 1'b0;
            timeout <= 1'b0;
            retired <= '0;
        end else begin
            if (cur_state == DECODE && !legal) begin
                illegal <= 1'b1;
            end
            if (wait_expired) begin
                timeout <= 1'b1;
            end
            if (pc_we && cur_state != TRAP && retired != '1) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign state = cur_state;

endmodule
